// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: per-channel OFF/ON/BLINK/BURST with a shared tick prescaler.
// Optional BLINK_SYNC_EN adds a sync input that realigns prescaler and all running channels.
module led_blink_multi #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRESCALE     = 1,
  parameter int unsigned DEFAULT_HALF = 50_000_000,
  parameter logic [1:0]  RESET_MODE   = 2'b10,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [7:0]        cfg_burst,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
`ifdef BLINK_SYNC_EN
  ,
  input  logic              sync
`endif
);

  typedef enum logic [1:0] {
    M_OFF   = 2'b00,
    M_ON    = 2'b01,
    M_BLINK = 2'b10,
    M_BURST = 2'b11
  } mode_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else begin
      if (tick) pcnt <= '0;
      else      pcnt <= pcnt + 1'b1;
`ifdef BLINK_SYNC_EN
      if (sync) pcnt <= '0;
`endif
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_t            mode_q;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       left_q;
    logic             led_q;
    logic             busy_q;
    logic             done_q;
    logic             we_ch;
    logic             running;

    // Out-of-range channel numbers match no instance, so such writes vanish.
    assign we_ch   = cfg_we && (cfg_ch == CH_W'(i));
    assign running = (mode_q == M_BLINK) || (mode_q == M_BURST);

    assign led[i]  = led_q;
    assign busy[i] = busy_q;
    assign done[i] = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q <= mode_t'(RESET_MODE);
        half_q <= CNT_W'(DEFAULT_HALF);
        cnt_q  <= CNT_W'(DEFAULT_HALF);
        left_q <= '0;
        led_q  <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (we_ch) begin
          half_q <= cfg_half;
          cnt_q  <= cfg_half;
          left_q <= cfg_burst;
          led_q  <= (cfg_mode == M_ON);
          if (cfg_mode == M_BURST && cfg_burst == 8'd0) begin
            mode_q <= M_OFF;
            busy_q <= 1'b0;
          end else begin
            mode_q <= mode_t'(cfg_mode);
            busy_q <= (cfg_mode == M_BURST);
          end
        end else
`ifdef BLINK_SYNC_EN
        if (sync && running) begin
          cnt_q <= half_q;
          led_q <= 1'b0;
        end else
`endif
        if (tick && running) begin
          if (cnt_q == '0) begin
            cnt_q <= half_q;
            led_q <= !led_q;
            // A burst blink ends on the falling toggle; the last one retires the channel.
            if (mode_q == M_BURST && led_q) begin
              left_q <= left_q - 1'b1;
              if (left_q <= 8'd1) begin
                mode_q <= M_OFF;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      end
    end
  end

endmodule
